// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Owns the PC and drives the I-cache. Fetched words are buffered
//            toward decode in a small FIFO. Redirects seen during a miss are
//            deferred until the line fill ends.
// Options  : `define FETCH_PERF_CNT_EN adds saturating hit/miss/stall counters
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          INSTR_BYTES = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        cache_enable,
   output logic [63:0] cache_addr,
   output logic [1:0]  cache_rd_wr_evict_flag,
   input  logic [31:0] cache_read_data,
   input  logic [1:0]  cache_data_available,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_hits,
   output logic [31:0] perf_misses,
   output logic [31:0] perf_stall_cycles
`endif
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] c_depth   = CNT_W'(FIFO_DEPTH);
   localparam logic [1:0]       c_st_hit  = 2'd2;
   localparam logic [1:0]       c_st_miss = 2'd3;
   localparam logic [63:0]      c_pc_inc  = 64'(INSTR_BYTES);

   typedef enum logic [0:0] {
      S_FETCH = 1'b0,
      S_MISS  = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [63:0]      r_pc, w_pc_nxt;
   logic             r_redirect_pending, w_pending_nxt;
   logic [63:0]      r_redirect_target, w_target_nxt;
   logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [63:0]      r_mem_pc    [FIFO_DEPTH];
   logic [31:0]      r_mem_instr [FIFO_DEPTH];

   logic        w_pop, w_push, w_flush, w_has_room, w_enable, w_enter_miss;
   logic [63:0] w_redirect_tgt;

   assign w_pop          = out_valid & out_ready;
   assign w_has_room     = (r_count != c_depth) | w_pop;
   assign w_redirect_tgt = redirect_pc & ~64'h3;
   assign w_flush        = redirect_valid;

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_pending_nxt = r_redirect_pending;
      w_target_nxt  = r_redirect_target;
      w_push        = 1'b0;
      w_enable      = 1'b0;
      w_enter_miss  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_enable = w_has_room;
            if (redirect_valid) begin
               w_pc_nxt = w_redirect_tgt;
            end else if (w_enable && cache_data_available == c_st_hit) begin
               w_push   = 1'b1;
               w_pc_nxt = r_pc + c_pc_inc;
            end else if (w_enable && cache_data_available == c_st_miss) begin
               w_state_nxt  = S_MISS;
               w_enter_miss = 1'b1;
            end
         end
         S_MISS: begin
            // Address must stay put until the fill completes, whatever else happens.
            w_enable = 1'b1;
            if (redirect_valid) begin
               w_pending_nxt = 1'b1;
               w_target_nxt  = w_redirect_tgt;
            end
            if (cache_data_available == c_st_hit) begin
               w_state_nxt = S_FETCH;
               if (r_redirect_pending || redirect_valid) begin
                  w_pc_nxt      = redirect_valid ? w_redirect_tgt : r_redirect_target;
                  w_pending_nxt = 1'b0;
               end else begin
                  w_push   = 1'b1;
                  w_pc_nxt = r_pc + c_pc_inc;
               end
            end
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state            <= S_FETCH;
         r_pc               <= RESET_PC;
         r_redirect_pending <= 1'b0;
         r_redirect_target  <= 64'h0;
      end else begin
         r_state            <= w_state_nxt;
         r_pc               <= w_pc_nxt;
         r_redirect_pending <= w_pending_nxt;
         r_redirect_target  <= w_target_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_pc[r_wr_ptr]    <= r_pc;
         r_mem_instr[r_wr_ptr] <= cache_read_data;
      end
   end

   assign cache_enable           = w_enable & ~reset;
   assign cache_addr             = r_pc;
   assign cache_rd_wr_evict_flag = cache_enable ? 2'd1 : 2'd0;
   assign out_valid              = (r_count != '0);
   assign out_instr              = r_mem_instr[r_rd_ptr];
   assign out_pc                 = r_mem_pc[r_rd_ptr];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_hits, r_perf_misses, r_perf_stalls;
   logic        w_stall;

   assign w_stall = (r_state == S_MISS) || (r_count == c_depth);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_hits   <= 32'h0;
         r_perf_misses <= 32'h0;
         r_perf_stalls <= 32'h0;
      end else begin
         if (w_push && r_perf_hits != 32'hFFFF_FFFF)
            r_perf_hits <= r_perf_hits + 32'd1;
         if (w_enter_miss && r_perf_misses != 32'hFFFF_FFFF)
            r_perf_misses <= r_perf_misses + 32'd1;
         if (w_stall && r_perf_stalls != 32'hFFFF_FFFF)
            r_perf_stalls <= r_perf_stalls + 32'd1;
      end
   end

   assign perf_hits         = r_perf_hits;
   assign perf_misses       = r_perf_misses;
   assign perf_stall_cycles = r_perf_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Randomized scoreboard bench for fetch_stage with a queue-based
//            reference model of the PC, miss/redirect rules and fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [63:0] RESET_PC = 64'h1000;
   localparam int          DEPTH    = 4;
   localparam int          N_CYCLES = 5000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cache_enable;
   logic [63:0] cache_addr;
   logic [1:0]  cache_rd_wr_evict_flag;
   logic [31:0] cache_read_data = '0;
   logic [1:0]  cache_data_available = '0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_hits, perf_misses, perf_stall_cycles;
`endif

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .INSTR_BYTES(4)) dut (
      .clk(clk), .reset(reset),
      .cache_enable(cache_enable), .cache_addr(cache_addr),
      .cache_rd_wr_evict_flag(cache_rd_wr_evict_flag),
      .cache_read_data(cache_read_data), .cache_data_available(cache_data_available),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
      , .perf_hits(perf_hits), .perf_misses(perf_misses),
      .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      exp_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [63:0] m_pc = RESET_PC;
   bit          m_miss = 0;
   bit          m_pend = 0;
   logic [63:0] m_tgt = '0;
   bit          mon_popped = 0;
   longint unsigned m_hits = 0, m_misses = 0, m_stalls = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the FIFO head against the scoreboard, pops on handshake.
   always @(negedge clk) begin
      mon_popped = 0;
      if (!reset) begin
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         if (out_valid && exp_q.size() != 0) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
            if (out_ready) begin
               void'(exp_q.pop_front());
               mon_popped = 1;
            end
         end
      end
   end

   // Reference model: evaluates one cycle from the current inputs, after the monitor.
   always @(negedge clk) begin
      bit          exp_en;
      logic [63:0] tgt;
      #1;
      tgt = redirect_pc & ~64'h3;
      if (reset) begin
         chk("enable_in_reset", 64'(cache_enable), 64'd0);
         exp_q.delete();
         m_pc = RESET_PC; m_miss = 0; m_pend = 0;
         m_hits = 0; m_misses = 0; m_stalls = 0;
      end else begin
         exp_en = m_miss || (exp_q.size() < DEPTH);
         chk("cache_enable", 64'(cache_enable), 64'(exp_en));
         chk("rd_flag", 64'(cache_rd_wr_evict_flag), exp_en ? 64'd1 : 64'd0);
         if (exp_en) chk("cache_addr", cache_addr, m_pc);
         if (m_miss || (exp_q.size() + int'(mon_popped) == DEPTH)) m_stalls++;
         if (!m_miss) begin
            if (redirect_valid) begin
               exp_q.delete();
               m_pc = tgt;
            end else if (exp_en && cache_data_available == 2'd2) begin
               exp_q.push_back('{pc: m_pc, instr: cache_read_data});
               m_hits++;
               m_pc = m_pc + 64'd4;
            end else if (exp_en && cache_data_available == 2'd3) begin
               m_miss = 1;
               m_misses++;
            end
         end else begin
            if (redirect_valid) begin
               exp_q.delete();
               m_pend = 1;
               m_tgt  = tgt;
            end
            if (cache_data_available == 2'd2) begin
               m_miss = 0;
               if (m_pend) begin
                  m_pc   = m_tgt;
                  m_pend = 0;
               end else begin
                  exp_q.push_back('{pc: m_pc, instr: cache_read_data});
                  m_hits++;
                  m_pc = m_pc + 64'd4;
               end
            end
         end
      end
`ifdef FETCH_PERF_CNT_EN
      @(posedge clk); #1;
      chk("perf_hits", 64'(perf_hits), 64'(m_hits));
      chk("perf_misses", 64'(perf_misses), 64'(m_misses));
      chk("perf_stalls", 64'(perf_stall_cycles), 64'(m_stalls));
`endif
   end

   // Stimulus: cache behaviour follows the model's miss state so fills look realistic.
   initial begin
      int r;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
         @(posedge clk);
         #1;
         reset           = (cyc >= 2500 && cyc < 2502);
         cache_read_data = $urandom();
         r = int'($urandom_range(0, 99));
         if (m_miss)
            cache_data_available = (r < 25) ? 2'd2 : ((r < 60) ? 2'd1 : 2'd3);
         else
            cache_data_available = (r < 75) ? 2'd2 : ((r < 90) ? 2'd3 : 2'd1);
         if (cyc < 300)       out_ready = 1'b1;
         else if (cyc < 700)  out_ready = ($urandom_range(0, 9) == 0);
         else                 out_ready = ($urandom_range(0, 9) < 7);
         redirect_valid = (cyc >= 300) && ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 7) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF5;
         else                           redirect_pc = {$urandom(), $urandom()};
      end
      redirect_valid = 1'b0;
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch unit that sits directly upstream of the 2-way set-associative instruction cache.
- Owns the PC and drives the cache's addr / enable / read-flag inputs.
- Interprets the cache's 2-bit data_available status and buffers fetched 32-bit instructions in a small FIFO toward decode.
- Handles redirects (branch/jump) without corrupting an in-flight cache line fill.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- FIFO_DEPTH, 4, fetch buffer entries; power of two, 2..16.
- INSTR_BYTES, 4, PC increment per fetched instruction.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cache_enable  out  1  cache enable
- cache_addr  out  64  fetch address to cache
- cache_rd_wr_evict_flag  out  2  always 2'd1 (READ) when enabled, else 2'd0
- cache_read_data  in  32  instruction word from cache
- cache_data_available  in  2  1=waiting for mem read, 2=hit, 3=miss/flush in progress
- redirect_valid  in  1  one-cycle redirect request
- redirect_pc  in  64  redirect target; bits [1:0] ignored (forced 0)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_pc  out  64  head PC

Behaviour:
- Reset, synchronous, active-high; clock clk.
- Reset values: pc=RESET_PC, state=FETCH, FIFO empty, out_valid=0, cache_enable=0, redirect_pending=0.
- Reset mid-miss is unconditional: all state is dropped; the cache is reset by the same signal.
- State FETCH:
  - cache_enable=1 and cache_addr=pc when the FIFO has at least one free slot (counting a same-cycle pop); otherwise cache_enable=0.
  - cache_data_available==2 with enable high: push {pc, cache_read_data}; pc <= pc+INSTR_BYTES. Hit-to-push latency is 0 cycles; the entry is visible at out_* the next cycle.
  - cache_data_available==3 with enable high: go to MISS; pc is held.
- State MISS:
  - cache_enable=1 and cache_addr=pc held stable every cycle, regardless of FIFO occupancy or redirect.
  - Stay in MISS while the status is 1 or 3.
  - On status 2: if redirect_pending=0, push and advance pc as in FETCH; if redirect_pending=1, discard the word, pc <= latched target, clear the pending flag. In both cases go to FETCH.
- Redirect:
  - In FETCH: flush the FIFO, pc <= {redirect_pc[63:2],2'b0}, no push that cycle even on a hit.
  - In MISS: flush the FIFO now; latch the target and set redirect_pending. A second redirect while pending overwrites the target.
  - Redirect in the same cycle as a pop: flush wins; out_valid=0 next cycle.
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Push is never attempted when full without a pop.
- out_instr/out_pc come straight from the head entry; they are stable while out_valid & !out_ready.
- PC arithmetic is 64-bit and wraps silently at 2^64.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_hits (out, 32), perf_misses (out, 32) and perf_stall_cycles (out, 32), all reset to 0.
  - perf_hits increments on every push.
  - perf_misses increments on each FETCH->MISS transition.
  - perf_stall_cycles increments on each cycle in MISS or with a full FIFO in FETCH.
  - All three saturate at 32'hFFFF_FFFF.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0x1000, cache returns hit every cycle, out_ready=1 -> out_pc sequence 0x1000,0x1004,0x1008 on consecutive cycles starting 1 cycle after the first enabled cycle.
- First access status 3, then 1 for 10 cycles, then 2 -> cache_addr held at 0x1000 throughout; exactly one push with pc 0x1000; next address 0x1004.
- out_ready=0, continuous hits, FIFO_DEPTH=4 -> after 4 pushes, cache_enable=0 and out_valid stays 1 with head pc 0x1000; out_ready=1 for one cycle -> 0x1004 at head; fetch resumes.
- Redirect to 0x2003 in FETCH with 3 entries buffered -> out_valid=0 next cycle; cache_addr=0x2000; the first output after that is pc 0x2000.
- Redirect to 0x3000 during MISS at 0x1000 -> cache_addr stays 0x1000 until status 2; that word is discarded; the next cache_addr is 0x3000; there is no output with pc 0x1000.
- With FETCH_PERF_CNT_EN: 5 hits, 1 miss lasting 6 cycles -> perf_hits=6, perf_misses=1, perf_stall_cycles=6.
